// File: rtl/dct_row_transpose_ctrl.sv
// Row-DCT sequencer and single 8x8 transpose buffer: captures 8 row-DCT results,
// then streams the block out column by column to the column-DCT stage.
module dct_row_transpose_ctrl #(
    parameter int DRAIN_COLS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        row_valid,
    output logic        row_ready,
    input  logic [63:0] row_data,
    output logic [63:0] dct_in,
    input  logic [71:0] dct_out,
    output logic        col_valid,
    input  logic        col_ready,
    output logic [71:0] col_data,
    output logic [2:0]  col_idx,
    output logic        blk_done,
    output logic        busy
);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [2:0] LAST_ROW = 3'd7;
    localparam logic [2:0] LAST_COL = 3'(DRAIN_COLS - 1);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  row_cnt_r;
    logic [2:0]  row_cnt_s;
    logic [2:0]  col_cnt_r;
    logic [2:0]  col_cnt_s;
    logic        blk_done_r;
    logic        blk_done_s;
    logic        row_ready_s;
    logic        col_valid_s;
    logic        wr_en_s;
    logic [71:0] col_sel_s;
    logic [71:0] row_buf_r [8];

    // Coefficient k of a 72-bit row word; coefficient 0 sits in the MSBs.
    function automatic logic [8:0] coef_field(input logic [71:0] word, input logic [2:0] k);
        return word[71 - 9 * int'(k) -: 9];
    endfunction

    // Next-state, handshake and capture-enable decode; flush overrides everything.
    always_comb begin
        state_s     = state_r;
        row_cnt_s   = row_cnt_r;
        col_cnt_s   = col_cnt_r;
        blk_done_s  = 1'b0;
        row_ready_s = 1'b0;
        col_valid_s = 1'b0;
        wr_en_s     = 1'b0;
        if (flush) begin
            state_s   = FILL;
            row_cnt_s = 3'd0;
            col_cnt_s = 3'd0;
        end else begin
            case (state_r)
                FILL: begin
                    row_ready_s = 1'b1;
                    if (row_valid) begin
                        wr_en_s = 1'b1;
                        if (row_cnt_r == LAST_ROW) begin
                            row_cnt_s = 3'd0;
                            col_cnt_s = 3'd0;
                            state_s   = DRAIN;
                        end else begin
                            row_cnt_s = row_cnt_r + 3'd1;
                        end
                    end else begin
                        row_cnt_s = row_cnt_r;
                    end
                end
                DRAIN: begin
                    col_valid_s = 1'b1;
                    if (col_ready) begin
                        if (col_cnt_r == LAST_COL) begin
                            col_cnt_s  = 3'd0;
                            state_s    = FILL;
                            blk_done_s = 1'b1;
                        end else begin
                            col_cnt_s = col_cnt_r + 3'd1;
                        end
                    end else begin
                        col_cnt_s = col_cnt_r;
                    end
                end
                default: begin
                    state_s   = FILL;
                    row_cnt_s = 3'd0;
                    col_cnt_s = 3'd0;
                end
            endcase
        end
    end

    // State, counters, done pulse and the transpose buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= FILL;
            row_cnt_r  <= 3'd0;
            col_cnt_r  <= 3'd0;
            blk_done_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                row_buf_r[i] <= 72'd0;
            end
        end else begin
            state_r    <= state_s;
            row_cnt_r  <= row_cnt_s;
            col_cnt_r  <= col_cnt_s;
            blk_done_r <= blk_done_s;
            if (wr_en_s) begin
                row_buf_r[row_cnt_r] <= dct_out;
            end
        end
    end

    // Column mux: field r of the output is row r's coefficient col_cnt.
    always_comb begin
        col_sel_s = 72'd0;
        for (int r = 0; r < 8; r++) begin
            col_sel_s[71 - 9 * r -: 9] = coef_field(row_buf_r[r], col_cnt_r);
        end
    end

    // Outputs are forced quiet while reset is held, independent of stale state.
    assign dct_in    = row_data;
    assign row_ready = rst_n & row_ready_s;
    assign col_valid = rst_n & col_valid_s;
    assign col_data  = rst_n ? col_sel_s : 72'd0;
    assign col_idx   = rst_n ? col_cnt_r : 3'd0;
    assign blk_done  = rst_n & blk_done_r;
    assign busy      = rst_n & ((state_r == DRAIN) | (row_cnt_r != 3'd0));

endmodule

// File: tb/tb_dct_row_transpose_ctrl.sv
// Self-checking bench for dct_row_transpose_ctrl: table vectors, directed corner
// sequences, and random handshake traffic against a block-level reference model.
module tb_dct_row_transpose_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, row_valid, col_ready;
    logic [63:0] row_data;
    logic [71:0] dct_out;

    logic        row_ready, col_valid, blk_done, busy;
    logic [63:0] dct_in;
    logic [71:0] col_data;
    logic [2:0]  col_idx;

    logic        row_ready7, col_valid7, blk_done7, busy7;
    logic [63:0] dct_in7;
    logic [71:0] col_data7;
    logic [2:0]  col_idx7;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dct_row_transpose_ctrl #(.DRAIN_COLS(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .dct_in(dct_in), .dct_out(dct_out),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
        .col_idx(col_idx), .blk_done(blk_done), .busy(busy)
    );

    dct_row_transpose_ctrl #(.DRAIN_COLS(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .row_valid(row_valid), .row_ready(row_ready7), .row_data(row_data),
        .dct_in(dct_in7), .dct_out(dct_out),
        .col_valid(col_valid7), .col_ready(col_ready), .col_data(col_data7),
        .col_idx(col_idx7), .blk_done(blk_done7), .busy(busy7)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // 72-bit word whose 9-bit field k holds base + stride*k.
    function automatic logic [71:0] pack(input int base, input int stride);
        logic [71:0] w;
        w = 72'd0;
        for (int k = 0; k < 8; k++) begin
            w[71 - 9 * k -: 9] = 9'(base + stride * k);
        end
        return w;
    endfunction

    // Apply inputs on the falling edge and let combinational outputs settle.
    task automatic drive(input logic rv, input logic cr, input logic fl,
                         input logic [71:0] d, input logic [63:0] rd);
        @(negedge clk);
        rst_n = 1'b1; row_valid = rv; col_ready = cr; flush = fl;
        dct_out = d; row_data = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; row_valid = 1'b0; col_ready = 1'b0; flush = 1'b0;
        dct_out = 72'd0; row_data = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n, rv, cr, fl;
        logic [71:0] dout;
        logic        rr, cv;
        logic [2:0]  idx;
        logic [71:0] cdata;
        logic        done, busy;
    } vec_t;

    vec_t vt [19];

    // Reference model state: rows captured so far, columns already sent.
    logic [71:0] m_blk [8];
    int          m_rows, m_cols, m_blocks;
    logic        m_done;

    function automatic logic [71:0] m_column(input int c);
        logic [71:0] w;
        logic [71:0] row;
        w = 72'd0;
        for (int r = 0; r < 8; r++) begin
            row = m_blk[r];
            w[71 - 9 * r -: 9] = row[71 - 9 * c -: 9];
        end
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; row_valid = 1'b0; col_ready = 1'b0;
        row_data = 64'd0; dct_out = 72'd0;

        // ---- Table: reset, 8 rows of constant r, 8 columns, done pulse ----
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 72'd0, 1'b0, 1'b0, 3'd0, 72'd0, 1'b0, 1'b0};
        for (int r = 0; r < 8; r++) begin
            vt[1 + r] = '{1'b1, 1'b1, 1'b1, 1'b0, pack(r, 0), 1'b1, 1'b0, 3'd0, 72'd0,
                          1'b0, (r != 0)};
        end
        for (int c = 0; c < 8; c++) begin
            vt[9 + c] = '{1'b1, 1'b1, 1'b1, 1'b0, {72{1'b1}}, 1'b0, 1'b1, 3'(c), pack(0, 1),
                          1'b0, 1'b1};
        end
        vt[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 72'd0, 1'b1, 1'b0, 3'd0, 72'd0, 1'b1, 1'b0};
        vt[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 72'd0, 1'b1, 1'b0, 3'd0, 72'd0, 1'b0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_n = vt[i].rst_n; row_valid = vt[i].rv; col_ready = vt[i].cr;
            flush = vt[i].fl; dct_out = vt[i].dout; row_data = 64'd0;
            #1;
            chk($sformatf("tbl%0d row_ready", i), 72'(row_ready), 72'(vt[i].rr));
            chk($sformatf("tbl%0d col_valid", i), 72'(col_valid), 72'(vt[i].cv));
            chk($sformatf("tbl%0d blk_done", i), 72'(blk_done), 72'(vt[i].done));
            chk($sformatf("tbl%0d busy", i), 72'(busy), 72'(vt[i].busy));
            if (vt[i].cv || !vt[i].rst_n) begin
                chk($sformatf("tbl%0d col_idx", i), 72'(col_idx), 72'(vt[i].idx));
                chk($sformatf("tbl%0d col_data", i), col_data, vt[i].cdata);
            end
        end

        // ---- Transpose with a 5-cycle stall on column 3 ----
        do_reset();
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 1'b0, 1'b0, pack(8 * r, 1), 64'd0);
            chk("tp row_ready", 72'(row_ready), 72'd1);
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                for (int h = 0; h < 5; h++) begin
                    drive(1'b1, 1'b0, 1'b0, 72'd0, 64'd0);
                    chk("stall col_valid", 72'(col_valid), 72'd1);
                    chk("stall col_idx", 72'(col_idx), 72'd3);
                    chk("stall col_data", col_data, pack(3, 8));
                    chk("stall row_ready", 72'(row_ready), 72'd0);
                    chk("stall blk_done", 72'(blk_done), 72'd0);
                end
            end
            drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
            chk("tp col_idx", 72'(col_idx), 72'(c));
            chk("tp col_data", col_data, pack(c, 8));
        end
        drive(1'b0, 1'b0, 1'b0, 72'd0, 64'd0);
        chk("tp blk_done", 72'(blk_done), 72'd1);
        chk("tp busy idle", 72'(busy), 72'd0);
        drive(1'b0, 1'b0, 1'b0, 72'd0, 64'd0);
        chk("tp blk_done once", 72'(blk_done), 72'd0);

        // ---- Flush after 4 rows, then a fresh block ----
        do_reset();
        for (int r = 0; r < 4; r++) drive(1'b1, 1'b1, 1'b0, {8{9'h1AA}}, 64'd0);
        drive(1'b1, 1'b1, 1'b1, {8{9'h1AA}}, 64'd0);
        chk("fl busy before", 72'(busy), 72'd1);
        chk("fl row_ready", 72'(row_ready), 72'd0);
        drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
        chk("fl busy after", 72'(busy), 72'd0);
        chk("fl no done", 72'(blk_done), 72'd0);
        for (int r = 0; r < 8; r++) drive(1'b1, 1'b1, 1'b0, pack(64 + 8 * r, 1), 64'd0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
            chk("fl col_valid", 72'(col_valid), 72'd1);
            chk("fl col_data", col_data, pack(64 + c, 8));
            chk("fl done early", 72'(blk_done), 72'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
        chk("fl blk_done", 72'(blk_done), 72'd1);

        // ---- DRAIN_COLS=7 instance ----
        do_reset();
        for (int r = 0; r < 8; r++) drive(1'b1, 1'b1, 1'b0, pack(8 * r, 1), 64'h0123456789ABCDEF);
        chk("d7 dct_in", 72'(dct_in7), 72'(64'h0123456789ABCDEF));
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
            chk("d7 col_valid", 72'(col_valid7), 72'd1);
            chk("d7 col_idx", 72'(col_idx7), 72'(c));
            chk("d7 col_data", col_data7, pack(c, 8));
        end
        drive(1'b1, 1'b1, 1'b0, pack(100, 1), 64'd0);
        chk("d7 blk_done", 72'(blk_done7), 72'd1);
        chk("d7 col_valid end", 72'(col_valid7), 72'd0);
        chk("d7 row_ready in done", 72'(row_ready7), 72'd1);
        drive(1'b0, 1'b1, 1'b0, 72'd0, 64'd0);
        chk("d7 row0 taken", 72'(busy7), 72'd1);
        chk("d7 done once", 72'(blk_done7), 72'd0);

        // ---- Random traffic against the block-level model ----
        do_reset();
        m_rows = 0; m_cols = 0; m_blocks = 0; m_done = 1'b0;
        for (int i = 0; i < 8; i++) m_blk[i] = 72'd0;
        for (int cyc = 0; m_blocks < 100; cyc++) begin
            logic        rv, cr, fl, exp_rr, exp_cv, nxt_done;
            logic [95:0] rnd;
            logic [63:0] rd;
            if (cyc >= 20000) begin
                n_cmp++; n_bad++;
                $display("FAIL rnd timeout: got %0d blocks, expected 100", m_blocks);
                break;
            end
            rv  = ($urandom_range(0, 3) != 0);
            cr  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 99) == 0);
            rnd = {$urandom, $urandom, $urandom};
            rd  = {$urandom, $urandom};
            drive(rv, cr, fl, rnd[71:0], rd);
            exp_rr = !fl && (m_rows < 8);
            exp_cv = !fl && (m_rows == 8);
            chk("rnd row_ready", 72'(row_ready), 72'(exp_rr));
            chk("rnd col_valid", 72'(col_valid), 72'(exp_cv));
            chk("rnd busy", 72'(busy), 72'(m_rows != 0));
            chk("rnd blk_done", 72'(blk_done), 72'(m_done));
            chk("rnd dct_in", 72'(dct_in), 72'(rd));
            if (exp_cv) begin
                chk("rnd col_idx", 72'(col_idx), 72'(m_cols));
                chk("rnd col_data", col_data, m_column(m_cols));
            end
            nxt_done = 1'b0;
            if (fl) begin
                m_rows = 0; m_cols = 0;
            end else if (exp_rr && rv) begin
                m_blk[m_rows] = rnd[71:0];
                m_rows++;
            end else if (exp_cv && cr) begin
                m_cols++;
                if (m_cols == 8) begin
                    m_rows = 0; m_cols = 0; nxt_done = 1'b1; m_blocks++;
                end
            end
            m_done = nxt_done;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
